retire: RTL and testbench
=========================

# retire

Final pipeline stage: consumes `exec_result` records from the execution units (ALU, memory, `misc`), writes the register file, and acts on branch/exception/xRET indications. It holds the M-mode trap CSRs (`mstatus`, `mtvec`, `mepc`, `mcause`, `mtval`), drives the fetch redirect, and emits the pipeline flush. While a redirect is outstanding it stalls further results.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `MTVEC_RESET`, 32'h0000_0000, reset value of `mtvec`.
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `res`  decoupled.in  exec_result  result stream; `res.data` carries `exec_result` plus `pc`.
- `rf_we` / `rf_idx` / `rf_val`  out  1 / 5 / 32  register-file write port, registered.
- `redir_valid` / `redir_target` / `redir_ready`  out / out / in  1 / 32 / 1  fetch redirect handshake.
- `flush`  out  1  one-cycle kill of all in-flight younger work.
- `csr_addr` / `csr_we` / `csr_wdata`  in  12 / 1 / 32  CSR access from the CSR instruction unit.
- `csr_rdata`  out  32  combinational read of `csr_addr`.

## Operation
- States: `RUN`, `REDIR`. `res.ready = (state == RUN)`. Accept = `res.valid && res.ready`.
- Priority on accept: `ex_valid` > `ret_valid` > `br_valid` > plain.
- Trap (`ex_valid`), and `br_valid` with `br_target[1] == 1` (raised as `EX_INSTR_MISALIGNED`, `mtval = br_target`):
  - `mepc <= pc`; `mcause <=` zero-extended ex code; `mtval <=` 0 unless misaligned.
  - `MPIE <= MIE`; `MIE <= 0`.
  - Target `{mtvec[31:2], 2'b00}`. No RF write. Go to `REDIR`.
- `ret_valid`: `MIE <= MPIE`; `MPIE <= 1`. Target `mepc`. No RF write. Go to `REDIR`.
- `br_valid`: RF write of `rd_val`. Target `br_target`. Go to `REDIR`.
- Plain: RF write of `rd_val`. Stay in `RUN`.
- RF write is suppressed when `rd_idx == 0`.
- `REDIR`: `redir_valid` is held high with a stable `redir_target` until `redir_ready`. Return to `RUN` in the cycle after the handshake.
- CSRs:
  - `mstatus` 0x300: only MIE[3] and MPIE[7] are implemented; other bits read 0.
  - `mtvec` 0x305, `mepc` 0x341 (bits [1:0] read 0), `mcause` 0x342, `mtval` 0x343.
  - Unimplemented addresses read 0; writes to them are ignored.
- Same-cycle CSR write and trap/xRET update of the same field: the trap/xRET update wins. Unrelated fields take the CSR write.

## Timing
- Reset values: all outputs 0; `state = RUN`; `mtvec = MTVEC_RESET`; all other CSRs 0.
- RF write appears in cycle N+1 for an accept in cycle N, held for one cycle.
- `redir_valid` rises in cycle N+1. `flush` pulses high in N+1 only.
- Earliest next accept: the cycle after `redir_ready` is seen. Minimum redirect turnaround is 2 cycles.
- CSR state updates at the clock edge ending the accept cycle. `csr_rdata` in cycle N+1 reflects the update.
- `rst` asserted mid-`REDIR` returns the block to `RUN` and drops `redir_valid`. No flush is emitted on reset.

## Configuration
- `RETIRE_COUNTERS_EN` defined: adds 64-bit `mcycle` (0xB00/0xB80) and `minstret` (0xB02/0xB82).
  - `mcycle` increments every non-reset cycle.
  - `minstret` increments once per accept that is not a trap (xRET counts).
  - A CSR write to a counter half overrides that cycle's increment.
  - Carry from the low half into the high half is honoured.
  - Both reset to 0.
- Undefined: these addresses read 0 and no counter flops exist.

## Structure
- Shared package `types.sv` holds:
  - `retire_state_e`
  - CSR address constants
  - `MSTATUS_MIE`/`MSTATUS_MPIE` bit indices
  - `EX_INSTR_MISALIGNED` added to `ex_type`
- Sub-module `retire_csr`: CSR storage, read mux, trap/xRET update logic and optional counters. The top level keeps the FSM, priority decode and output registers.

## Test plan
- Plain result, `rd_idx=5`, `rd_val=32'hDEAD_BEEF` -> `rf_we=1`, `rf_idx=5`, `rf_val=32'hDEAD_BEEF` next cycle; no redirect. Same with `rd_idx=0` -> `rf_we=0`.
- `ex_valid`, `EX_M_ECALL`, `pc=32'h100`, `mtvec=32'h200`, MIE=1:
  - next cycle `redir_valid=1`, `redir_target=32'h200`, `flush=1`.
  - `mepc=32'h100`, `mcause=11`, MIE=0, MPIE=1.
- Then `ret_valid` -> `redir_target=32'h100`, MIE=1. With `redir_ready` held 0 for 3 cycles: `res.ready=0` and target stable throughout.
- `br_valid`, `br_target=32'h402`, `pc=32'h40` -> trap, `mcause=0`, `mtval=32'h402`, no RF write.
- CSR write `mstatus=0` in the same cycle as an ecall with MIE=1 -> MPIE=1, MIE=0.
- `RETIRE_COUNTERS_EN` defined: write `mcycle` low half = 32'hFFFF_FFFF -> after one more cycle high half = 1, low half = 0. `minstret` counts 3 plain results and ignores 1 trap.

Source files
------------

// File: rtl/retire_pkg.sv
// Shared types for the retire stage: result record, exception codes, FSM states, CSR map.
package retire_pkg;

   typedef enum logic [3:0] {
      EX_INSTR_MISALIGNED = 4'd0,
      EX_ILLEGAL_INSTR    = 4'd2,
      EX_BREAKPOINT       = 4'd3,
      EX_LOAD_MISALIGNED  = 4'd4,
      EX_LOAD_FAULT       = 4'd5,
      EX_STORE_MISALIGNED = 4'd6,
      EX_STORE_FAULT      = 4'd7,
      EX_U_ECALL          = 4'd8,
      EX_M_ECALL          = 4'd11
   } ex_type;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd_idx;
      logic [31:0] rd_val;
      logic        ex_valid;
      ex_type      ex_code;
      logic        ret_valid;
      logic        br_valid;
      logic [31:0] br_target;
   } exec_result;

   typedef enum logic {
      RUN   = 1'b0,
      REDIR = 1'b1
   } retire_state_e;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

endpackage

// File: rtl/retire_csr.sv
// M-mode trap CSRs with trap/xRET update and read mux.
// Optional mcycle/minstret counters when RETIRE_COUNTERS_EN is defined.
module retire_csr
   import retire_pkg::*;
#(
   parameter int unsigned      XLEN        = 32,
   parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [11:0]     csr_addr,
   input  logic            csr_we,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   input  logic            trap,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret,
`ifdef RETIRE_COUNTERS_EN
   input  logic            retired,
`endif
   output logic [XLEN-1:0] mtvec,
   output logic [XLEN-1:0] mepc
);

   logic            mie_q;
   logic            mpie_q;
   logic [XLEN-1:0] mcause_q;
   logic [XLEN-1:0] mtval_q;
   logic [XLEN-1:0] mstatus_rd;

   localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

   always_ff @(posedge clk) begin
      if (rst) begin
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         mtvec    <= MTVEC_RESET;
         mepc     <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
      end else begin
         if (csr_we) begin
            case (csr_addr)
               CSR_MSTATUS: begin
                  mie_q  <= csr_wdata[MSTATUS_MIE];
                  mpie_q <= csr_wdata[MSTATUS_MPIE];
               end
               CSR_MTVEC:  mtvec    <= csr_wdata;
               CSR_MEPC:   mepc     <= csr_wdata & ALIGN_MASK;
               CSR_MCAUSE: mcause_q <= csr_wdata;
               CSR_MTVAL:  mtval_q  <= csr_wdata;
               default: ;
            endcase
         end
         // Later assignments win, so trap/xRET updates override a colliding CSR write.
         if (trap) begin
            mepc     <= trap_pc & ALIGN_MASK;
            mcause_q <= trap_cause;
            mtval_q  <= trap_tval;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
         end else if (mret) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
         end
      end
   end

   always_comb begin
      mstatus_rd               = '0;
      mstatus_rd[MSTATUS_MIE]  = mie_q;
      mstatus_rd[MSTATUS_MPIE] = mpie_q;
   end

`ifdef RETIRE_COUNTERS_EN
   logic [63:0] mcycle_q;
   logic [63:0] minstret_q;
   logic [63:0] mcycle_d;
   logic [63:0] minstret_d;

   // A write to one half replaces only that half; the full 64-bit add keeps the carry otherwise.
   always_comb begin
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, retired};
      if (csr_we) begin
         case (csr_addr)
            CSR_MCYCLE:    mcycle_d          = {mcycle_q[63:32], csr_wdata};
            CSR_MCYCLEH:   mcycle_d[63:32]   = csr_wdata;
            CSR_MINSTRET:  minstret_d        = {minstret_q[63:32], csr_wdata};
            CSR_MINSTRETH: minstret_d[63:32] = csr_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end
`endif

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_MSTATUS:   csr_rdata = mstatus_rd;
         CSR_MTVEC:     csr_rdata = mtvec;
         CSR_MEPC:      csr_rdata = mepc;
         CSR_MCAUSE:    csr_rdata = mcause_q;
         CSR_MTVAL:     csr_rdata = mtval_q;
`ifdef RETIRE_COUNTERS_EN
         CSR_MCYCLE:    csr_rdata = mcycle_q[31:0];
         CSR_MCYCLEH:   csr_rdata = mcycle_q[63:32];
         CSR_MINSTRET:  csr_rdata = minstret_q[31:0];
         CSR_MINSTRETH: csr_rdata = minstret_q[63:32];
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/retire.sv
// Retire stage: priority decode of results, RF write, redirect/flush FSM.
// RETIRE_COUNTERS_EN adds mcycle/minstret inside retire_csr.
module retire
   import retire_pkg::*;
#(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            res_valid,
   output logic            res_ready,
   input  exec_result      res_data,
   output logic            rf_we,
   output logic [4:0]      rf_idx,
   output logic [XLEN-1:0] rf_val,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_target,
   input  logic            redir_ready,
   output logic            flush,
   input  logic [11:0]     csr_addr,
   input  logic            csr_we,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata
);

   retire_state_e   state_q;
   retire_state_e   state_d;
   logic            accept;
   logic            take_trap;
   logic            take_ret;
   logic            redirect;
   logic            rf_write;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] cause;
   logic [XLEN-1:0] tval;
   logic [XLEN-1:0] mtvec;
   logic [XLEN-1:0] mepc;

   assign res_ready   = (state_q == RUN);
   assign redir_valid = (state_q == REDIR);
   assign accept      = res_valid && res_ready;

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      take_trap = 1'b0;
      take_ret  = 1'b0;
      redirect  = 1'b0;
      rf_write  = 1'b0;
      target    = res_data.br_target;
      cause     = '0;
      tval      = '0;
      case (state_q)
         RUN: begin
            if (accept) begin
               if (res_data.ex_valid) begin
                  take_trap = 1'b1;
                  cause     = {{(XLEN-4){1'b0}}, res_data.ex_code};
               end else if (res_data.ret_valid) begin
                  take_ret = 1'b1;
                  target   = mepc;
               end else if (res_data.br_valid && res_data.br_target[1]) begin
                  take_trap = 1'b1;
                  cause     = {{(XLEN-4){1'b0}}, EX_INSTR_MISALIGNED};
                  tval      = res_data.br_target;
               end else begin
                  rf_write = 1'b1;
               end
               if (take_trap) target = mtvec & ~(XLEN'(3));
               redirect = take_trap || take_ret || res_data.br_valid;
               if (redirect) state_d = REDIR;
            end
         end
         REDIR: begin
            if (redir_ready) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we        <= 1'b0;
         rf_idx       <= '0;
         rf_val       <= '0;
         flush        <= 1'b0;
         redir_target <= '0;
      end else begin
         rf_we <= rf_write && (res_data.rd_idx != 5'd0);
         if (rf_write && (res_data.rd_idx != 5'd0)) begin
            rf_idx <= res_data.rd_idx;
            rf_val <= res_data.rd_val;
         end
         flush <= redirect;
         if (redirect) redir_target <= target;
      end
   end

   retire_csr #(
      .XLEN        (XLEN),
      .MTVEC_RESET (MTVEC_RESET)
   ) u_csr (
      .clk        (clk),
      .rst        (rst),
      .csr_addr   (csr_addr),
      .csr_we     (csr_we),
      .csr_wdata  (csr_wdata),
      .csr_rdata  (csr_rdata),
      .trap       (take_trap),
      .trap_pc    (res_data.pc),
      .trap_cause (cause),
      .trap_tval  (tval),
      .mret       (take_ret),
`ifdef RETIRE_COUNTERS_EN
      .retired    (accept && !take_trap),
`endif
      .mtvec      (mtvec),
      .mepc       (mepc)
   );

endmodule

// File: tb/tb_retire.sv
// Randomized self-checking bench for retire against a transaction-level CSR/redirect model.
module tb_retire;
   import retire_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        res_valid;
   logic        res_ready;
   exec_result  res_data;
   logic        rf_we;
   logic [4:0]  rf_idx;
   logic [31:0] rf_val;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        redir_ready;
   logic        flush;
   logic [11:0] csr_addr;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   always #5 clk = ~clk;

   retire #(.XLEN(32), .MTVEC_RESET(32'h0)) dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .rf_we(rf_we), .rf_idx(rf_idx), .rf_val(rf_val),
      .redir_valid(redir_valid), .redir_target(redir_target), .redir_ready(redir_ready),
      .flush(flush), .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
      .csr_rdata(csr_rdata)
   );

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   bit          m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval;
   longint unsigned m_instret;

   ex_type codes [9] = '{EX_INSTR_MISALIGNED, EX_ILLEGAL_INSTR, EX_BREAKPOINT,
                         EX_LOAD_MISALIGNED, EX_LOAD_FAULT, EX_STORE_MISALIGNED,
                         EX_STORE_FAULT, EX_U_ECALL, EX_M_ECALL};
   logic [11:0] csr_list [6] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h7C0};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mie = 0; m_mpie = 0;
      m_mtvec = 32'h0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
      m_instret = 0;
   endfunction

   function automatic void model_write(input logic [11:0] a, input logic [31:0] d);
      case (a)
         12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
         12'h305: m_mtvec = d;
         12'h341: m_mepc = d & ~32'h3;
         12'h342: m_mcause = d;
         12'h343: m_mtval = d;
         default: ;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h343: return m_mtval;
         default: return 32'h0;
      endcase
   endfunction

   task automatic rd(input logic [11:0] a, output logic [31:0] v);
      csr_addr = a;
      #1;
      v = csr_rdata;
   endtask

   // Only called while idle in RUN, so CSR contents are stable across the reads.
   task automatic check_csrs();
      logic [31:0] v;
      foreach (csr_list[i]) begin
         rd(csr_list[i], v);
         check($sformatf("csr_%0h", csr_list[i]), v, model_read(csr_list[i]));
      end
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      csr_we = 1; csr_addr = a; csr_wdata = d;
      model_write(a, d);
      @(negedge clk);
      csr_we = 0;
   endtask

   task automatic send(input exec_result r, input bit wr, input logic [11:0] wa,
                       input logic [31:0] wd, input int unsigned hold);
      bit is_trap, is_ret, is_redir, exp_we, old_mie, old_mpie;
      logic [31:0] tgt, cause, tval;
      exec_result g;
      @(negedge clk);
      check("ready_before", res_ready, 1'b1);
      res_data = r; res_valid = 1; csr_we = wr; csr_addr = wa; csr_wdata = wd;
      is_trap  = r.ex_valid || (!r.ret_valid && r.br_valid && r.br_target[1]);
      is_ret   = !r.ex_valid && r.ret_valid;
      is_redir = is_trap || is_ret || r.br_valid;
      exp_we   = !is_trap && !is_ret && (r.rd_idx != 0);
      tgt      = is_trap ? (m_mtvec & ~32'h3) : (is_ret ? m_mepc : r.br_target);
      cause    = r.ex_valid ? 32'(r.ex_code) : 32'd0;
      tval     = r.ex_valid ? 32'd0 : r.br_target;
      old_mie = m_mie; old_mpie = m_mpie;
      if (wr) model_write(wa, wd);
      if (is_trap) begin
         m_mepc = r.pc & ~32'h3; m_mcause = cause; m_mtval = tval;
         m_mpie = old_mie; m_mie = 0;
      end else begin
         if (is_ret) begin m_mie = old_mpie; m_mpie = 1; end
         m_instret++;
      end
      @(negedge clk);
      res_valid = 0; csr_we = 0;
      check("rf_we", rf_we, exp_we);
      if (exp_we) begin
         check("rf_idx", rf_idx, r.rd_idx);
         check("rf_val", rf_val, r.rd_val);
      end
      check("flush", flush, is_redir);
      check("redir_valid", redir_valid, is_redir);
      if (!is_redir) return;
      check("redir_target", redir_target, tgt);
      g = '0; g.rd_idx = 5'd7; g.rd_val = 32'h1234_5678;
      for (int unsigned i = 0; i < hold; i++) begin
         res_data = g; res_valid = 1;
         @(negedge clk);
         check("hold_ready", res_ready, 1'b0);
         check("hold_valid", redir_valid, 1'b1);
         check("hold_target", redir_target, tgt);
         check("hold_flush", flush, 1'b0);
         check("hold_rf_we", rf_we, 1'b0);
      end
      res_valid = 0; redir_ready = 1;
      @(negedge clk);
      redir_ready = 0;
      check("post_valid", redir_valid, 1'b0);
      check("post_ready", res_ready, 1'b1);
      check("post_rf_we", rf_we, 1'b0);
   endtask

   function automatic exec_result rand_res();
      exec_result r;
      int unsigned k;
      r = '0;
      k = $urandom_range(0, 9);
      r.pc = $urandom() & ~32'h3;
      r.rd_idx = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.rd_val = $urandom();
      r.ex_code = codes[$urandom_range(0, 8)];
      r.br_target = $urandom() & ~32'h1;
      if (k < 2) begin
         r.ex_valid = 1; r.ret_valid = 1'($urandom()); r.br_valid = 1'($urandom());
      end else if (k == 2) begin
         r.ret_valid = 1; r.br_valid = 1'($urandom());
      end else if (k < 5) begin
         r.br_valid = 1;
      end
      return r;
   endfunction

   initial begin
      exec_result r;
      logic [31:0] v, v2;
      rst = 1; res_valid = 0; res_data = '0; redir_ready = 0;
      csr_addr = '0; csr_we = 0; csr_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_rf_we", rf_we, 1'b0);
      check("rst_rf_idx", rf_idx, 5'd0);
      check("rst_rf_val", rf_val, 32'h0);
      check("rst_redir_valid", redir_valid, 1'b0);
      check("rst_redir_target", redir_target, 32'h0);
      check("rst_flush", flush, 1'b0);
      check("rst_ready", res_ready, 1'b1);
      check_csrs();
      @(negedge clk);
      rst = 0;

      r = '0; r.rd_idx = 5'd5; r.rd_val = 32'hDEAD_BEEF;
      send(r, 0, 12'h0, 32'h0, 0);
      r.rd_idx = 5'd0;
      send(r, 0, 12'h0, 32'h0, 0);

      csr_write(12'h305, 32'h200);
      csr_write(12'h300, 32'h8);
      r = '0; r.ex_valid = 1; r.ex_code = EX_M_ECALL; r.pc = 32'h100;
      send(r, 0, 12'h0, 32'h0, 0);
      rd(12'h341, v); check("ecall_mepc", v, 32'h100);
      rd(12'h342, v); check("ecall_mcause", v, 32'd11);
      rd(12'h300, v); check("ecall_mstatus", v, 32'h80);

      r = '0; r.ret_valid = 1;
      send(r, 0, 12'h0, 32'h0, 3);
      rd(12'h300, v); check("mret_mstatus", v, 32'h88);

      r = '0; r.br_valid = 1; r.br_target = 32'h402; r.pc = 32'h40; r.rd_idx = 5'd9;
      send(r, 0, 12'h0, 32'h0, 1);
      rd(12'h342, v); check("misal_mcause", v, 32'd0);
      rd(12'h343, v); check("misal_mtval", v, 32'h402);

      csr_write(12'h300, 32'h8);
      r = '0; r.ex_valid = 1; r.ex_code = EX_M_ECALL; r.pc = 32'h300;
      send(r, 1, 12'h300, 32'h0, 0);
      rd(12'h300, v); check("collide_mstatus", v, 32'h80);
      check_csrs();

      // Reset while a redirect is outstanding.
      @(negedge clk);
      r = '0; r.ex_valid = 1; r.ex_code = EX_BREAKPOINT; r.pc = 32'h500;
      res_data = r; res_valid = 1;
      @(negedge clk);
      res_valid = 0;
      check("pre_rst_redir", redir_valid, 1'b1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      model_reset();
      check("rst_redir_drop", redir_valid, 1'b0);
      check("rst_no_flush", flush, 1'b0);
      check("rst_ready_run", res_ready, 1'b1);
      check_csrs();

      csr_write(12'h305, $urandom() & ~32'h3);
      for (int n = 0; n < 250; n++) begin
         bit wr;
         wr = ($urandom_range(0, 3) == 0);
         send(rand_res(), wr, csr_list[$urandom_range(0, 5)], $urandom(), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            check("idle_rf_we", rf_we, 1'b0);
            check("idle_flush", flush, 1'b0);
         end
         if (n % 25 == 0) check_csrs();
      end
      check_csrs();

`ifdef RETIRE_COUNTERS_EN
      rd(12'hB02, v); check("minstret_lo", v, m_instret[31:0]);
      rd(12'hB82, v); check("minstret_hi", v, m_instret[63:32]);
      rd(12'hB02, v2);
      r = '0; r.rd_idx = 5'd3;
      repeat (3) send(r, 0, 12'h0, 32'h0, 0);
      r.ex_valid = 1; r.ex_code = EX_ILLEGAL_INSTR;
      send(r, 0, 12'h0, 32'h0, 0);
      rd(12'hB02, v); check("minstret_delta", v - v2, 32'd3);
      csr_write(12'hB00, 32'hFFFF_FFFF);
      rd(12'hB00, v); check("mcycle_written", v, 32'hFFFF_FFFF);
      rd(12'hB80, v); check("mcycle_hi_before", v, 32'h0);
      @(negedge clk);
      rd(12'hB80, v); check("mcycle_carry_hi", v, 32'h1);
      rd(12'hB00, v); check("mcycle_carry_lo", v, 32'h0);
`else
      rd(12'hB00, v); check("no_mcycle", v, 32'h0);
      rd(12'hB02, v); check("no_minstret", v, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
